// File: rtl/aes_pkg.sv
// Shared definitions for the AES key schedule: key-length codes,
// per-length sizing lookups, GF(2^8) doubling and the controller states.
package aes_pkg;

    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_BAD = 2'b11
    } key_len_e;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    function automatic logic [5:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd6;
            KL_256:  return 6'd8;
            default: return 6'd4;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd52;
            KL_256:  return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Request/read-port bundle of the key schedule; master issues keys,
// slave is the schedule engine.
interface aes_key_schedule_if;

    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         ready;
    logic         done;
    logic         err;
    logic [127:0] rk;
    logic [3:0]   nr;

    modport master (
        output start, key_len, key, rk_idx,
        input  busy, ready, done, err, rk, nr
    );

    modport slave (
        input  start, key_len, key, rk_idx,
        output busy, ready, done, err, rk, nr
    );

endinterface

// File: rtl/aes_key_schedule_sbox.sv
// 32-bit word S-box: four parallel byte substitutions from one
// shared forward AES table.
module sbox (
    input  logic [31:0] a,
    output logic [31:0] y
);

    // Byte b lives at bits [8*(255-b) +: 8]
    localparam logic [2047:0] TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] lu(input logic [7:0] b);
        return TAB[{~b, 3'b000} +: 8];
    endfunction

    assign y = {lu(a[31:24]), lu(a[23:16]),
                lu(a[15:8]),  lu(a[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion, one 32-bit word per clock, with a
// combinational round-key read port over the stored schedule.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int EN_192 = 1,
    parameter int EN_256 = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_key_schedule_if.slave    bus
);

    state_t      state;
    logic [31:0] w [MAX_WORDS];
    logic [5:0]  i;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic [1:0]  len_q;
    logic [3:0]  nr_q;
    logic        busy_q;
    logic        ready_q;
    logic        done_q;
    logic        err_q;

    logic [5:0]  nk;
    logic [5:0]  nw;
    logic [31:0] prev;
    logic [31:0] old;
    logic [31:0] sb_in;
    logic [31:0] sb_out;
    logic [31:0] temp;
    logic [31:0] nxt;
    logic        use_rot;
    logic        sub_only;
    logic        last;
    logic        legal;
    logic [5:0]  base;

    assign nk = nk_of(len_q);
    assign nw = nw_of(len_q);

    always_comb begin
        legal = 1'b0;
        case (bus.key_len)
            KL_128:  legal = 1'b1;
            KL_192:  legal = (EN_192 != 0);
            KL_256:  legal = (EN_256 != 0);
            default: legal = 1'b0;
        endcase
    end

    // phase tracks i mod Nk so no divider is needed
    always_comb begin
        prev     = w[i - 6'd1];
        old      = w[i - nk];
        use_rot  = (phase == 3'd0);
        sub_only = (nk == 6'd8) && (phase == 3'd4);
        sb_in    = use_rot ? {prev[23:0], prev[31:24]} : prev;
        unique case (1'b1)
            use_rot:  temp = sb_out ^ {rcon, 24'h0};
            sub_only: temp = sb_out;
            default:  temp = prev;
        endcase
        nxt  = old ^ temp;
        last = (i == nw - 6'd1);
    end

    sbox u_sbox (
        .a (sb_in),
        .y (sb_out)
    );

    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        if (reset) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            nr_q    <= 4'd0;
            i       <= 6'd0;
            phase   <= 3'd0;
            rcon    <= 8'h01;
            len_q   <= KL_128;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && legal) begin
                        // Surplus words are rewritten by the expansion
                        for (int k = 0; k < 8; k++)
                            w[6'(k)] <= bus.key[255 - 32*k -: 32];
                        len_q   <= bus.key_len;
                        i       <= nk_of(bus.key_len);
                        phase   <= 3'd0;
                        rcon    <= 8'h01;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        nr_q    <= 4'd0;
                        state   <= EXPAND;
                    end else if (bus.start) begin
                        err_q <= 1'b1;
                    end
                end
                EXPAND: begin
                    w[i]  <= nxt;
                    i     <= i + 6'd1;
                    phase <= ({3'b000, phase} == nk - 6'd1)
                             ? 3'd0 : phase + 3'd1;
                    if (use_rot)
                        rcon <= xtime(rcon);
                    if (last) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        nr_q    <= nr_of(len_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign base = {bus.rk_idx, 2'b00};

    always_comb begin
        bus.rk = '0;
        if (ready_q && (bus.rk_idx <= nr_q))
            bus.rk = {w[base], w[base + 6'd1],
                      w[base + 6'd2], w[base + 6'd3]};
    end

    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.nr    = nr_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: a GF(2^8)-derived reference
// expansion checks every round key, latency, nr and error pulses.
module tb_aes_key_schedule;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   nchk  = 0;
    int   nfail = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_key_schedule_if bus ();
    aes_key_schedule_if bus2 ();

    aes_key_schedule u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    aes_key_schedule #(
        .EN_192 (1),
        .EN_256 (0)
    ) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef logic [31:0] sched_t [60];

    typedef struct {
        bit           is_err;
        logic [1:0]   len;
        logic [255:0] key;
        int           exp_cyc;
        bit           kat;
        logic [127:0] kat_rk;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] sbt [256];

    localparam logic [255:0] K128 =
        {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] R128 =
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [255:0] K192 =
        {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [127:0] R192 =
        128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256 =
        128'hfe4890d1e6188d0b046df344706c631e;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in,
                                          input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse, then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbt[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                       ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int j);
        logic [7:0] r = 8'h01;
        for (int n = 1; n < j; n++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    function automatic sched_t expand(input logic [255:0] k, input int nk);
        sched_t      ws;
        logic [31:0] t;
        int          nw;
        nw = 4 * (nk + 7);
        for (int n = 0; n < 60; n++) ws[n] = '0;
        for (int n = 0; n < nk; n++) ws[n] = k[255 - 32*n -: 32];
        for (int n = nk; n < nw; n++) begin
            t = ws[n-1];
            if (n % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_of(n / nk), 24'h0};
            else if (nk == 8 && n % nk == 4)
                t = subw(t);
            ws[n] = ws[n-nk] ^ t;
        end
        return ws;
    endfunction

    task automatic push_exp(input logic [255:0] k, input logic [1:0] l,
                            input bit kat, input logic [127:0] krk);
        exp_t e;
        int   nk;
        nk       = 4 + 2 * int'(l);
        e.is_err = (l == 2'b11);
        e.len    = l;
        e.key    = k;
        e.kat    = kat;
        e.kat_rk = krk;
        e.exp_cyc = cyc + 1 + (e.is_err ? 0 : 4 * (nk + 7) - nk);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [255:0] k, input logic [1:0] l,
                         input bit kat, input logic [127:0] krk);
        push_exp(k, l, kat, krk);
        bus.start   = 1'b1;
        bus.key     = k;
        bus.key_len = l;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 200);
        if (bus.busy) begin
            nchk++;
            nfail++;
            $display("FAIL idle_timeout: got busy=1 required 0 in 200 cycles");
        end
    endtask

    // Monitor: pops one expectation per done/err pulse
    initial begin
        exp_t        e;
        sched_t      ws;
        int          nrx;
        logic [127:0] want;
        bus.rk_idx = 4'd10;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || !(bus.done || bus.err)) continue;
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_event: got done=%0b err=%0b required none",
                         bus.done, bus.err);
                continue;
            end
            e = sb.pop_front();
            chk("event_err", 256'(bus.err), 256'(e.is_err));
            chk("event_cycle", 256'(cyc), 256'(e.exp_cyc));
            if (!e.is_err && bus.done) begin
                nrx = 10 + 2 * int'(e.len);
                ws  = expand(e.key, 4 + 2 * int'(e.len));
                chk("nr", 256'(bus.nr), 256'(nrx));
                chk("ready", 256'(bus.ready), 256'(1'b1));
                for (int r = 0; r < 16; r++) begin
                    bus.rk_idx = 4'(r);
                    #1;
                    want = '0;
                    if (r <= nrx)
                        want = {ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]};
                    chk($sformatf("rk[%0d]", r), 256'(bus.rk), 256'(want));
                end
                if (e.kat) begin
                    bus.rk_idx = 4'(nrx);
                    #1;
                    chk("kat_rk", 256'(bus.rk), 256'(e.kat_rk));
                end
                bus.rk_idx = 4'd10;
            end
        end
    end

    initial begin
        logic [255:0] kb;
        logic [1:0]   l;
        int           n;
        build_sbox();
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.key_len  = 2'b00;
        bus.key      = '0;
        bus2.start   = 1'b0;
        bus2.key_len = 2'b00;
        bus2.key     = '0;
        bus2.rk_idx  = 4'd10;
        repeat (3) @(negedge clk);
        chk("rst_busy",  256'(bus.busy),  256'(1'b0));
        chk("rst_ready", 256'(bus.ready), 256'(1'b0));
        chk("rst_done",  256'(bus.done),  256'(1'b0));
        chk("rst_err",   256'(bus.err),   256'(1'b0));
        chk("rst_nr",    256'(bus.nr),    256'(4'd0));
        chk("rst_rk",    256'(bus.rk),    256'(128'h0));
        reset = 1'b0;
        @(negedge clk);

        // Instance without AES-256 support
        bus2.start = 1'b1;
        bus2.key   = K128;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        for (n = 0; n < 100 && !bus2.ready; n++) @(negedge clk);
        chk("dut2_ready", 256'(bus2.ready), 256'(1'b1));
        chk("dut2_rk", 256'(bus2.rk), 256'(R128));
        bus2.start   = 1'b1;
        bus2.key     = K256;
        bus2.key_len = 2'b10;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        @(negedge clk);
        chk("dut2_err", 256'(bus2.err), 256'(1'b1));
        chk("dut2_keep_ready", 256'(bus2.ready), 256'(1'b1));
        chk("dut2_keep_nr", 256'(bus2.nr), 256'(4'd10));
        chk("dut2_keep_rk", 256'(bus2.rk), 256'(R128));
        @(negedge clk);
        chk("dut2_err_pulse", 256'(bus2.err), 256'(1'b0));

        issue(K128, 2'b00, 1'b1, R128);
        wait_idle();
        issue(K192, 2'b01, 1'b1, R192);
        wait_idle();
        issue(K256, 2'b10, 1'b1, R256);
        wait_idle();
        issue(K128, 2'b00, 1'b1, R128);
        wait_idle();

        issue(K256, 2'b11, 1'b0, 128'h0);
        wait_idle();
        chk("bad_keep_ready", 256'(bus.ready), 256'(1'b1));
        chk("bad_keep_nr", 256'(bus.nr), 256'(4'd10));
        chk("bad_keep_rk", 256'(bus.rk), 256'(R128));
        @(negedge clk);

        // Abort an AES-256 run part-way
        issue(K256, 2'b10, 1'b1, R256);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        chk("abort_busy",  256'(bus.busy),  256'(1'b0));
        chk("abort_ready", 256'(bus.ready), 256'(1'b0));
        chk("abort_nr",    256'(bus.nr),    256'(4'd0));
        chk("abort_rk",    256'(bus.rk),    256'(128'h0));
        repeat (60) @(negedge clk);
        issue(K128, 2'b00, 1'b1, R128);
        wait_idle();

        // start held high; key swapped mid-run
        push_exp(K128, 2'b00, 1'b1, R128);
        bus.start   = 1'b1;
        bus.key     = K128;
        bus.key_len = 2'b00;
        @(posedge clk);
        #1;
        repeat (10) @(negedge clk);
        for (int j = 0; j < 8; j++) kb[32*j +: 32] = $urandom;
        bus.key = kb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        chk("held_done", 256'(bus.done), 256'(1'b1));
        push_exp(kb, 2'b00, 1'b0, 128'h0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("held_restart_busy", 256'(bus.busy), 256'(1'b1));
        chk("held_restart_ready", 256'(bus.ready), 256'(1'b0));
        wait_idle();

        repeat (8) begin
            l = 2'($urandom_range(0, 3));
            for (int j = 0; j < 8; j++) kb[32*j +: 32] = $urandom;
            issue(kb, l, 1'b0, 128'h0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 256'(sb.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have parameter EN_192, default 1, meaning AES-192 key length supported (0: start with key_len=01 rejected).
REQ-002 SHALL have parameter EN_256, default 1, meaning AES-256 key length supported (0: start with key_len=10 rejected).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request expansion of key; sampled only when busy=0.
REQ-006 key_len  input  2  00=AES-128, 01=AES-192, 10=AES-256, 11=invalid.
REQ-007 key  input  256  cipher key, left-aligned: 128-bit in [255:128], 192-bit in [255:64].
REQ-008 rk_idx  input  4  round-key index 0..Nr for read port.
REQ-009 busy  output  1  expansion in progress.
REQ-010 ready  output  1  level: full schedule valid for the last accepted key.
REQ-011 done  output  1  single-cycle pulse on completion.
REQ-012 err  output  1  single-cycle pulse on rejected start.
REQ-013 rk  output  128  round key rk_idx, {w[4r],w[4r+1],w[4r+2],w[4r+3]}, combinational from storage.
REQ-014 nr  output  4  round count of stored schedule (10/12/14), 0 when ready=0.

Function
REQ-015 Nk/Nr/word total SHALL be 4/10/44, 6/12/52, 8/14/60 for key_len 00/01/10.
REQ-016 Word storage SHALL be 60 x 32 bits; w[0] = most-significant 32 bits of key.
REQ-017 States SHALL be IDLE, EXPAND; IDLE->EXPAND on accepted start; EXPAND->IDLE after last word.
REQ-018 Accepted start (IDLE, start=1, legal and enabled key_len) SHALL load w[0..Nk-1] on that edge, set busy=1, clear ready, set word counter i=Nk, rcon=0x01.
REQ-019 Rejected start (key_len=11 or disabled length) SHALL pulse err for one cycle and leave storage, ready, nr unchanged.
REQ-020 EXPAND SHALL compute exactly one word per clock, w[i], i incrementing by 1.
REQ-021 i mod Nk = 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon then updates to xtime(rcon) (0x80 -> 0x1b).
REQ-022 Nk=8 and i mod 8 = 4: w[i] = w[i-8] ^ SubWord(w[i-1]).
REQ-023 Otherwise: w[i] = w[i-Nk] ^ w[i-1].
REQ-024 Exactly one 32-bit S-box word lookup SHALL be used; input muxed between RotWord and plain word.
REQ-025 On the edge writing the last word: busy->0, ready->1, done=1 for the following cycle only, nr set.
REQ-026 Latency: done high in cycle Nw-Nk after start edge (40/46/52 cycles).
REQ-027 start while busy=1 SHALL be ignored (no err, no restart).
REQ-028 start on the done cycle SHALL be accepted normally; ready drops on that edge.
REQ-029 rk SHALL be 0 when ready=0 or rk_idx > Nr.

Reset
REQ-030 reset SHALL force IDLE, busy=0, ready=0, done=0, err=0, nr=0, i=0, rcon=0x01; priority over start.
REQ-031 reset mid-EXPAND SHALL abort with no done pulse; storage contents need not be cleared.

Structure
REQ-032 Shared package aes_pkg SHALL hold key_len encodings, Nk/Nr/word-count lookup functions, xtime function, state enum, MAX_WORDS=60.
REQ-033 One sub-module: the existing 32-bit word S-box sbox, instantiated once.

Verification
REQ-034 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> done at cycle 40; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; nr=10.
REQ-035 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done at cycle 46; rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
REQ-036 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done at cycle 52; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
REQ-037 key_len=11 start, then EN_256=0 with key_len=10 -> err pulse each, ready/rk of prior AES-128 schedule unchanged.
REQ-038 reset at cycle 20 of AES-256 run -> no done, ready=0, rk=0; restart AES-128 key -> REQ-034 result.
REQ-039 start held high during AES-128 run, key changed mid-run -> first key's schedule produced, second start accepted on done cycle.
